// File: rtl/fp_convert_unit.sv
// fp_convert_unit: fixed-latency int32 <-> IEEE-754 single conversion unit
// with a custom-instruction handshake (start/done, clk_en, opcode n).
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   clk_en          pipeline advance enable; all state holds when low
//   reset_req       synchronous pipeline flush (qualified by clk_en)
//   start           accept dataa/n this cycle (qualified by clk_en)
//   dataa           operand: integer or float bits depending on n
//   datab           unused operand
//   n               opcode: 0 fixsi, 1 roundsi, 2 floatis, 3 floatiu/floatis
//   done            one-cycle result-valid pulse
//   result          conversion result, held until the next done
//
// Build option: define FP_CONVERT_UNSIGNED_EN to make n=3 an unsigned
// int-to-float conversion; otherwise n=3 is identical to n=2.
module fp_convert_unit #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned N_WIDTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               reset_req,
  input  logic               start,
  input  logic [31:0]        dataa,
  input  logic [31:0]        datab,
  input  logic [N_WIDTH-1:0] n,
  output logic               done,
  output logic [31:0]        result
);

  // Pipeline stages before the output register; stage 0 holds raw operands.
  localparam int unsigned DEPTH = LATENCY - 1;

  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [31:0]        data_q [DEPTH];
  logic [31:0]        data_d [DEPTH];
  logic [N_WIDTH-1:0] op_q, op_d;
  logic               done_q, done_d;
  logic [31:0]        result_q, result_d;
  logic [31:0]        conv_c;
  logic [31:0]        last_c;
  logic               unused_datab_c;

  assign unused_datab_c = ^datab;

  // Float to int32 with saturation; rnd selects ties-away rounding over truncation.
  function automatic logic [31:0] f2i(input logic [31:0] f, input logic rnd);
    logic [7:0]  e;
    logic [7:0]  sh;
    logic [32:0] q;
    logic [31:0] mag;
    e   = f[30:23];
    sh  = 8'd158 - e;
    // q = floor(2*|x|): integer part plus the half bit in q[0].
    q   = {1'b1, f[22:0], 9'b0} >> sh;
    mag = q[32:1] + {31'b0, rnd & q[0]};
    if (e == 8'hFF && f[22:0] != 23'd0)
      f2i = 32'h7FFF_FFFF;
    else if (e >= 8'd158)
      f2i = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else if (e < 8'd126)
      f2i = 32'd0;
    else
      f2i = f[31] ? (~mag + 32'd1) : mag;
  endfunction

  // Int32 to float, round-to-nearest-even.
  function automatic logic [31:0] i2f(input logic [31:0] a, input logic sgnd);
    logic        neg;
    logic [31:0] mag;
    logic [31:0] norm;
    logic [4:0]  pos;
    logic        round_up;
    logic [24:0] sig;
    logic [7:0]  ex;
    neg = sgnd & a[31];
    mag = neg ? (~a + 32'd1) : a;
    pos = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) pos = 5'(i);
    end
    norm     = mag << (5'd31 - pos);
    // guard=norm[7], round=norm[6], sticky=|norm[5:0], lsb=norm[8]
    round_up = norm[7] & (norm[8] | norm[6] | (|norm[5:0]));
    sig      = {1'b0, norm[31:8]} + {24'b0, round_up};
    ex       = 8'd127 + {3'b0, pos} + {7'b0, sig[24]};
    if (mag == 32'd0)
      i2f = 32'd0;
    else if (sig[24])
      i2f = {neg, ex, sig[23:1]};
    else
      i2f = {neg, ex, sig[22:0]};
  endfunction

  // Opcode dispatch on the stage-0 operand.
  function automatic logic [31:0] convert(input logic [31:0] a, input logic [N_WIDTH-1:0] op);
    if (op == N_WIDTH'(0))
      convert = f2i(a, 1'b0);
    else if (op == N_WIDTH'(1))
      convert = f2i(a, 1'b1);
`ifdef FP_CONVERT_UNSIGNED_EN
    else if (op == N_WIDTH'(3))
      convert = i2f(a, 1'b0);
`endif
    else
      convert = i2f(a, 1'b1);
  endfunction

  // Next-state: shift the valid/data pipe on enabled cycles.
  always_comb begin
    conv_c   = convert(data_q[0], op_q);
    last_c   = (DEPTH == 1) ? conv_c : data_q[DEPTH-1];
    valid_d  = valid_q;
    data_d   = data_q;
    op_d     = op_q;
    done_d   = 1'b0;
    result_d = result_q;
    if (clk_en) begin
      if (reset_req) begin
        valid_d = '0;
      end else begin
        done_d = valid_q[DEPTH-1];
        if (valid_q[DEPTH-1]) result_d = last_c;
        valid_d[0] = start;
        if (start) begin
          data_d[0] = dataa;
          op_d      = n;
        end
        for (int k = 1; k < int'(DEPTH); k++) begin
          valid_d[k] = valid_q[k-1];
          data_d[k]  = (k == 1) ? conv_c : data_q[k-1];
        end
      end
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      valid_q  <= valid_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Datapath payload, qualified by the valid bits.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    op_q   <= op_d;
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_fp_convert_unit.sv
module tb_fp_convert_unit;
  localparam int unsigned LATENCY = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b0;
  logic        reset_req = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dataa = 32'd0;
  logic [31:0] datab = 32'd0;
  logic [1:0]  n = 2'd0;
  logic        done;
  logic [31:0] result;

  always #5 clk = ~clk;

  fp_convert_unit #(.LATENCY(LATENCY), .N_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .reset_req(reset_req),
    .start(start), .dataa(dataa), .datab(datab), .n(n),
    .done(done), .result(result)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit arm = 1'b0;

  typedef struct { logic [31:0] val; int age; } fl_t;
  fl_t         pipe[$];
  logic        exp_done = 1'b0;
  logic [31:0] exp_result = 32'd0;
  int          done_cyc[$];
  logic [31:0] done_res[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %08h want %08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: signed/unsigned int32 -> float, RNE via integer quotient/remainder.
  function automatic logic [31:0] m_i2f(input logic [31:0] a, input bit sgnd);
    bit s;
    longint m, q, r, half;
    int e, sh;
    s = sgnd && a[31];
    m = s ? -longint'($signed(a)) : longint'({32'd0, a});
    if (m == 0) return 32'd0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      sh   = e - 23;
      q    = m >> sh;
      r    = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (r > half || (r == half && (q & 1) == 1)) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {s, 8'(e + 127), 23'(q)};
  endfunction

  // Reference: float -> int32, exact value then clamp to the int32 range.
  function automatic logic [31:0] m_f2i(input logic [31:0] f, input bit rnd);
    int e, sh;
    longint mant, v, r;
    e    = int'(f[30:23]);
    mant = longint'({41'd0, 1'b1, f[22:0]});
    if (e == 255 && f[22:0] != 23'd0) return 32'h7FFF_FFFF;
    if (e == 0) return 32'd0;
    if (e >= 190) v = longint'(1) << 40;
    else if (e >= 150) v = mant << (e - 150);
    else begin
      sh = 150 - e;
      if (sh >= 40) v = 0;
      else begin
        v = mant >> sh;
        r = mant - (v << sh);
        if (rnd && r >= (longint'(1) << (sh - 1))) v++;
      end
    end
    if (f[31]) v = -v;
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_conv(input logic [31:0] a, input logic [1:0] op);
    case (op)
      2'd0: return m_f2i(a, 1'b0);
      2'd1: return m_f2i(a, 1'b1);
`ifdef FP_CONVERT_UNSIGNED_EN
      2'd3: return m_i2f(a, 1'b0);
`endif
      default: return m_i2f(a, 1'b1);
    endcase
  endfunction

  // Transaction model: each accepted op completes after LATENCY enabled edges.
  always @(posedge clk) begin
    if (reset) begin
      pipe.delete();
      exp_done = 1'b0;
      exp_result = 32'd0;
    end else if (!clk_en) begin
      exp_done = 1'b0;
    end else if (reset_req) begin
      pipe.delete();
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      foreach (pipe[i]) pipe[i].age--;
      if (pipe.size() > 0 && pipe[0].age == 0) begin
        exp_done = 1'b1;
        exp_result = pipe[0].val;
        void'(pipe.pop_front());
      end
      if (start) pipe.push_back('{ref_conv(dataa, n), int'(LATENCY) - 1});
    end
  end

  // Monitor: compare every cycle against the model and log completions.
  always @(negedge clk) begin
    cyc++;
    if (arm) begin
      chk("mon_done", 32'(done), 32'(exp_done));
      chk("mon_result", result, exp_result);
      if (done === 1'b1) begin
        done_cyc.push_back(cyc);
        done_res.push_back(result);
      end
    end
  end

  task automatic drive(input bit st, input logic [31:0] a, input logic [1:0] op,
                       input bit en, input bit rq, input bit rs);
    @(negedge clk);
    #1;
    start = st; dataa = a; n = op; clk_en = en; reset_req = rq; reset = rs;
    datab = $urandom();
  endtask

  task automatic idle(input int k);
    repeat (k) drive(1'b0, 32'd0, 2'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic clear_log();
    done_cyc.delete();
    done_res.delete();
  endtask

  function automatic logic [31:0] gen_operand(input logic [1:0] op);
    logic [31:0] r;
    int sel, e;
    r   = $urandom();
    sel = $urandom_range(0, 9);
    if (op < 2) begin
      case (sel)
        0: r[30:23] = 8'hFF;
        1: r[30:23] = 8'h00;
        2: r[30:0]  = 31'h4F00_0000;
        3: begin
          e = $urandom_range(127, 149);
          r[30:23] = 8'(e);
          r = (r & ~((32'd1 << (150 - e)) - 32'd1)) | (32'd1 << (149 - e));
        end
        default: r[30:23] = 8'($urandom_range(110, 165));
      endcase
    end else begin
      case (sel)
        0: r = 32'($signed(r[23:0]));
        1: r = r >> $urandom_range(0, 31);
        2: r = 32'd0;
        3: r = {1'b0, 1'b1, 23'($urandom()), 1'b1, 6'd0};
        4: r = {1'b1, 1'b0, 23'($urandom()), 1'b1, 6'd0};
        default: ;
      endcase
    end
    return r;
  endfunction

  typedef struct { logic [1:0] op; logic [31:0] a; logic [31:0] expv; } vec_t;
  vec_t vecs[18];

  initial begin
    logic [31:0] b2b_in [5];
    logic [31:0] b2b_exp [5];
    int t0;

    vecs[0]  = '{2'd2, 32'h0100_0001, 32'h4B80_0000};
    vecs[1]  = '{2'd2, 32'h0100_0003, 32'h4B80_0002};
    vecs[2]  = '{2'd2, 32'hFFFF_FFFF, 32'hBF80_0000};
    vecs[3]  = '{2'd0, 32'h4049_0FDB, 32'h0000_0003};
    vecs[4]  = '{2'd1, 32'h4049_0FDB, 32'h0000_0003};
    vecs[5]  = '{2'd0, 32'hC020_0000, 32'hFFFF_FFFE};
    vecs[6]  = '{2'd1, 32'hC020_0000, 32'hFFFF_FFFD};
    vecs[7]  = '{2'd0, 32'h4F00_0000, 32'h7FFF_FFFF};
    vecs[8]  = '{2'd0, 32'h7FC0_0000, 32'h7FFF_FFFF};
    vecs[9]  = '{2'd0, 32'hCF80_0000, 32'h8000_0000};
`ifdef FP_CONVERT_UNSIGNED_EN
    vecs[10] = '{2'd3, 32'hFFFF_FFFF, 32'h4F80_0000};
`else
    vecs[10] = '{2'd3, 32'hFFFF_FFFF, 32'hBF80_0000};
`endif
    vecs[11] = '{2'd1, 32'h3F00_0000, 32'h0000_0001};
    vecs[12] = '{2'd0, 32'h3F00_0000, 32'h0000_0000};
    vecs[13] = '{2'd0, 32'hCF00_0000, 32'h8000_0000};
    vecs[14] = '{2'd1, 32'h3FC0_0000, 32'h0000_0002};
    vecs[15] = '{2'd2, 32'h00FF_FFFF, 32'h4B7F_FFFF};
    vecs[16] = '{2'd1, 32'h7F80_0000, 32'h7FFF_FFFF};
    vecs[17] = '{2'd0, 32'h0040_0000, 32'h0000_0000};

    b2b_in  = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    b2b_exp = '{32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h4F00_0000, 32'hCF00_0000};

    drive(1'b0, 32'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 32'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    arm = 1'b1;
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    idle(1);

    // Back-to-back floatis starts.
    clear_log();
    drive(1'b1, b2b_in[0], 2'd2, 1'b1, 1'b0, 1'b0);
    t0 = cyc;
    for (int i = 1; i < 5; i++) drive(1'b1, b2b_in[i], 2'd2, 1'b1, 1'b0, 1'b0);
    idle(LATENCY + 2);
    chk("b2b_count", 32'(done_cyc.size()), 32'd5);
    for (int i = 0; i < 5 && i < done_cyc.size(); i++) begin
      chk($sformatf("b2b%0d_cycle", i), 32'(done_cyc[i]), 32'(t0 + int'(LATENCY) + i));
      chk($sformatf("b2b%0d_result", i), done_res[i], b2b_exp[i]);
    end

    // Single-op vector table.
    foreach (vecs[i]) begin
      clear_log();
      drive(1'b1, vecs[i].a, vecs[i].op, 1'b1, 1'b0, 1'b0);
      t0 = cyc;
      idle(LATENCY + 1);
      chk($sformatf("vec%0d_count", i), 32'(done_cyc.size()), 32'd1);
      if (done_cyc.size() > 0) begin
        chk($sformatf("vec%0d_cycle", i), 32'(done_cyc[0]), 32'(t0 + int'(LATENCY)));
        chk($sformatf("vec%0d_result", i), done_res[0], vecs[i].expv);
      end
    end

    // Stall three cycles mid-flight; starts during the stall are ignored.
    clear_log();
    drive(1'b1, 32'd5, 2'd2, 1'b1, 1'b0, 1'b0);
    t0 = cyc;
    repeat (3) drive(1'b1, 32'd77, 2'd2, 1'b0, 1'b0, 1'b0);
    idle(6);
    chk("stall_count", 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() > 0) begin
      chk("stall_cycle", 32'(done_cyc[0]), 32'(t0 + 7));
      chk("stall_result", done_res[0], 32'h40A0_0000);
    end

    // Flush one cycle after start, and start together with flush.
    clear_log();
    drive(1'b1, 32'd5, 2'd2, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 32'd7, 2'd2, 1'b1, 1'b1, 1'b0);
    idle(6);
    chk("flush_count", 32'(done_cyc.size()), 32'd0);

    // Reset mid-flight clears result; start together with reset is ignored.
    clear_log();
    drive(1'b1, 32'd9, 2'd2, 1'b1, 1'b0, 1'b0);
    idle(1);
    drive(1'b0, 32'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 32'd9, 2'd2, 1'b1, 1'b0, 1'b1);
    idle(6);
    chk("rstfly_count", 32'(done_cyc.size()), 32'd0);
    chk("rstfly_result", result, 32'd0);

    // Randomized traffic against the transaction model.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      drive($urandom_range(0, 99) < 60, gen_operand(op), op,
            $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 3,
            $urandom_range(0, 199) < 1);
    end
    idle(LATENCY + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
